// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: FIFO-fed HD44780 write strobe sequencer.
// Define LCD_INIT_SEQ_EN to send 0x38,0x0C,0x06,0x01 after reset.
module lcd_write_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  input  logic                        wr_rs,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  lcd_data,
  output logic [1:0]                  lcd_ctrl,
  output logic                        lcd_enable
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [8:0]    head;
  logic          push;
  logic          pop;
  logic          init_done;

`ifdef LCD_INIT_SEQ_EN
  localparam logic BUSY_RST = 1'b1;
  logic [2:0] init_idx;
  logic [7:0] init_byte;

  assign init_done = init_idx[2];

  // Power-on command ROM.
  always_comb begin
    init_byte = 8'h00;
    unique case (init_idx[1:0])
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h06;
      2'd3: init_byte = 8'h01;
    endcase
  end
`else
  localparam logic BUSY_RST = 1'b0;
  assign init_done = 1'b1;
`endif

  assign wr_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == IDLE) && (fifo_level != '0)
                    && init_done;
  assign head     = mem[rptr];

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wr_rs, wr_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Strobe sequencer with registered LCD outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lcd_data   <= '0;
      lcd_ctrl   <= '0;
      lcd_enable <= 1'b0;
      busy       <= BUSY_RST;
`ifdef LCD_INIT_SEQ_EN
      init_idx   <= '0;
`endif
    end else begin
      busy <= (state != IDLE) || (fifo_level != '0)
              || !init_done;
      unique case (state)
        IDLE: begin
          lcd_enable <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
          if (!init_done) begin
            lcd_data <= init_byte;
            lcd_ctrl <= 2'b00;
            init_idx <= init_idx + 3'd1;
            cnt      <= CW'(SETUP_CYCLES - 1);
            state    <= SETUP;
          end else
`endif
          if (pop) begin
            lcd_data <= head[7:0];
            lcd_ctrl <= {head[8], 1'b0};
            cnt      <= CW'(SETUP_CYCLES - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b1;
            cnt        <= CW'(PULSE_CYCLES - 1);
            state      <= PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lcd_enable <= 1'b0;
            cnt        <= CW'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
